// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared divider definitions
// Purpose: ALU control codes for DIV/DIVU, the divider FSM state type,
//          the iteration count and an operand magnitude helper.
// Ports:   none (package).
package div_unit_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_STEPS = 32;
   localparam int DIV_CNT_W = $clog2(DIV_STEPS);

   // alucontrol codes decoded into start_i / signed_i and used by the HI/LO write mux
   localparam logic [4:0] DIV_CONTROL  = 5'b01010;
   localparam logic [4:0] DIVU_CONTROL = 5'b01011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_t;

   // Two's-complement magnitude for signed operands; raw value for unsigned ones.
   function automatic logic [DIV_WIDTH-1:0] magnitude(input logic [DIV_WIDTH-1:0] value,
                                                      input logic                 is_signed);
      return (is_signed && value[DIV_WIDTH-1]) ? DIV_WIDTH'(-value) : value;
   endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational radix-2 restoring division iteration
// Purpose: shift {rem, quot} left by one, trial-subtract the divisor and keep
//          the difference (setting the new quotient bit) when it is non-negative.
// Ports:   rem, quot, divisor in; next_rem, next_quot out (all 32 bits).
module div_step
   import div_unit_pkg::*;
(
   input  logic [DIV_WIDTH-1:0] rem,
   input  logic [DIV_WIDTH-1:0] quot,
   input  logic [DIV_WIDTH-1:0] divisor,
   output logic [DIV_WIDTH-1:0] next_rem,
   output logic [DIV_WIDTH-1:0] next_quot
);

   // The shifted remainder can reach 2*divisor-1, so it needs one extra bit,
   // and the difference one more for the borrow.
   logic [DIV_WIDTH:0]   rem_shift;
   logic [DIV_WIDTH+1:0] trial;

   always_comb begin
      rem_shift = {rem, quot[DIV_WIDTH-1]};
      trial     = {1'b0, rem_shift} - {2'b00, divisor};
      if (!trial[DIV_WIDTH+1]) begin
         next_rem  = trial[DIV_WIDTH-1:0];
         next_quot = {quot[DIV_WIDTH-2:0], 1'b1};
      end else begin
         next_rem  = rem_shift[DIV_WIDTH-1:0];
         next_quot = {quot[DIV_WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative 32-bit signed/unsigned divider for the EX stage
// Purpose: 32-cycle restoring divide producing quotient (LO) and remainder (HI),
//          stalling the pipeline while busy; divide-by-zero finishes in one cycle.
// Ports:   clk_i, rst_i (async, active-high); start_i, signed_i, ack_i, annul_i,
//          dividend_i, divisor_i in; stall_o, done_o, quot_o, rem_o out.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             signed_i,
   input  logic             ack_i,
   input  logic             annul_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             stall_o,
   output logic             done_o,
   output logic [WIDTH-1:0] quot_o,
   output logic [WIDTH-1:0] rem_o
);

   localparam logic [DIV_CNT_W-1:0] LAST_STEP = DIV_CNT_W'(DIV_STEPS - 1);

   div_state_t           state;
   logic [DIV_CNT_W-1:0] cnt;
   logic [WIDTH-1:0]     rem_q;
   logic [WIDTH-1:0]     quot_q;
   logic [WIDTH-1:0]     divisor_q;
   logic                 neg_quot;
   logic                 neg_rem;
   logic [WIDTH-1:0]     next_rem;
   logic [WIDTH-1:0]     next_quot;

   // quot_q starts as |dividend| and is shifted out into rem_q as quotient bits shift in.
   div_step u_step (
      .rem       (rem_q),
      .quot      (quot_q),
      .divisor   (divisor_q),
      .next_rem  (next_rem),
      .next_quot (next_quot)
   );

   // Low in DONE so the pipeline captures the result in that cycle.
   assign stall_o = start_i & ~done_o & ~annul_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE;
         cnt       <= '0;
         rem_q     <= '0;
         quot_q    <= '0;
         divisor_q <= '0;
         neg_quot  <= 1'b0;
         neg_rem   <= 1'b0;
         done_o    <= 1'b0;
         quot_o    <= '0;
         rem_o     <= '0;
      end else if (annul_i) begin
         // Abort without touching the visible results.
         state  <= IDLE;
         done_o <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  neg_quot  <= signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                  neg_rem   <= signed_i & dividend_i[WIDTH-1];
                  divisor_q <= magnitude(divisor_i, signed_i);
                  quot_q    <= magnitude(dividend_i, signed_i);
                  rem_q     <= '0;
                  cnt       <= '0;
                  if (divisor_i == '0) begin
                     state  <= DONE;
                     done_o <= 1'b1;
                     quot_o <= '1;
                     rem_o  <= dividend_i;
                  end else begin
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               rem_q  <= next_rem;
               quot_q <= next_quot;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST_STEP) begin
                  // Sign fix-up; 0x80000000 / -1 wraps back to 0x80000000.
                  state  <= DONE;
                  done_o <= 1'b1;
                  quot_o <= neg_quot ? WIDTH'(-next_quot) : next_quot;
                  rem_o  <= neg_rem  ? WIDTH'(-next_rem)  : next_rem;
               end
            end
            DONE: begin
               if (ack_i || !start_i) begin
                  state  <= IDLE;
                  done_o <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               done_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking scoreboard bench for div_unit
module tb_div_unit;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic        signed_i = 1'b0;
   logic        ack_i = 1'b0;
   logic        annul_i = 1'b0;
   logic [31:0] dividend_i = '0;
   logic [31:0] divisor_i = '0;
   logic        stall_o;
   logic        done_o;
   logic [31:0] quot_o;
   logic [31:0] rem_o;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      int          lat;
   } exp_t;

   exp_t        sb_q[$];
   int          tests = 0;
   int          errors = 0;
   logic [31:0] last_q = '0;
   logic [31:0] last_r = '0;

   div_unit #(.WIDTH(32)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .start_i    (start_i),
      .signed_i   (signed_i),
      .ack_i      (ack_i),
      .annul_i    (annul_i),
      .dividend_i (dividend_i),
      .divisor_i  (divisor_i),
      .stall_o    (stall_o),
      .done_o     (done_o),
      .quot_o     (quot_o),
      .rem_o      (rem_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: magnitude divide with the / and % operators, then sign fix-up.
   task automatic model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        output logic [31:0] q, output logic [31:0] r);
      logic [31:0] ua, ub, uq, ur;
      if (b == 0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else begin
         ua = (sgn && a[31]) ? -a : a;
         ub = (sgn && b[31]) ? -b : b;
         uq = ua / ub;
         ur = ua % ub;
         q  = (sgn && (a[31] ^ b[31])) ? -uq : uq;
         r  = (sgn && a[31]) ? -ur : ur;
      end
   endtask

   // Drive one divide from a negedge, count stall cycles until done, hold DONE
   // for 'hold' cycles with ack low, then ack and confirm the return to IDLE.
   task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [31:0] eq, input logic [31:0] er,
                         input int hold);
      exp_t e;
      int   stalls = 0;
      bit   seen = 0;
      e.q = eq; e.r = er; e.lat = (b == 0) ? 1 : 33;
      sb_q.push_back(e);
      start_i = 1'b1; signed_i = sgn; dividend_i = a; divisor_i = b; ack_i = 1'b0;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (done_o) begin
            seen = 1;
            break;
         end
         if (stall_o) stalls++;
         @(negedge clk_i);
      end
      e = sb_q.pop_front();
      check({tag, " done seen"}, 32'(seen), 32'd1);
      if (seen) begin
         check({tag, " quot"}, quot_o, e.q);
         check({tag, " rem"}, rem_o, e.r);
         check({tag, " stall cycles"}, 32'(stalls), 32'(e.lat));
         check({tag, " stall low at done"}, 32'(stall_o), 32'd0);
         for (int k = 0; k < hold; k++) begin
            @(negedge clk_i); #1;
            check({tag, " hold quot"}, quot_o, e.q);
            check({tag, " hold rem"}, rem_o, e.r);
            check({tag, " hold done"}, 32'(done_o), 32'd1);
         end
         last_q = e.q; last_r = e.r;
      end
      ack_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0; ack_i = 1'b0;
      #1;
      check({tag, " idle after ack"}, 32'(done_o), 32'd0);
      @(negedge clk_i);
   endtask

   task automatic rand_div(input logic sgn);
      logic [31:0] a, b, q, r;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(8, 28);
      if (b == 0) b = 32'd3;
      model(a, b, sgn, q, r);
      do_div(sgn ? "rand signed" : "rand unsigned", a, b, sgn, q, r, 0);
   endtask

   initial begin
      #1;
      check("reset quot", quot_o, 32'd0);
      check("reset rem", rem_o, 32'd0);
      check("reset done", 32'(done_o), 32'd0);
      check("reset stall", 32'(stall_o), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);

      do_div("100/7 u", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 0);
      do_div("-7/2 s", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
      do_div("7/-2 s", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 0);
      do_div("ovf s", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 0);
      do_div("max/1 u", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 0);
      do_div("div0 u", 32'h0000_1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_1234, 0);
      do_div("div0 s", 32'h0000_1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h0000_1234, 0);
      do_div("hold5 u", 32'd1000, 32'd33, 1'b0, 32'd30, 32'd10, 5);

      // Annul in BUSY cycle 10: no done, results untouched.
      start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd5000; divisor_i = 32'd9;
      for (int i = 0; i < 11; i++) @(negedge clk_i);
      annul_i = 1'b1;
      #1;
      check("annul stall low", 32'(stall_o), 32'd0);
      @(negedge clk_i);
      start_i = 1'b0; annul_i = 1'b0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (done_o) begin
            check("annul no done", 32'(done_o), 32'd0);
            break;
         end
         @(negedge clk_i);
      end
      check("annul quot kept", quot_o, last_q);
      check("annul rem kept", rem_o, last_r);
      do_div("after annul", 32'd5000, 32'd9, 1'b0, 32'd555, 32'd5, 0);

      // Asynchronous reset in the middle of BUSY.
      start_i = 1'b1; signed_i = 1'b1; dividend_i = 32'd77; divisor_i = 32'd5;
      for (int i = 0; i < 6; i++) @(negedge clk_i);
      #2 rst_i = 1'b1;
      #1;
      check("rst quot", quot_o, 32'd0);
      check("rst rem", rem_o, 32'd0);
      check("rst done", 32'(done_o), 32'd0);
      check("rst stall follows start", 32'(stall_o), 32'd1);
      @(negedge clk_i);
      rst_i = 1'b0; start_i = 1'b0;
      #1;
      check("post rst stall", 32'(stall_o), 32'd0);
      @(negedge clk_i);
      do_div("after rst", 32'd77, 32'd5, 1'b1, 32'd15, 32'd2, 0);

      for (int i = 0; i < 6; i++) rand_div(i[0]);

      check("scoreboard empty", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
